// File: rtl/cache_arb_pkg.sv
// Shared types and widths for the cache-to-memory arbiter and the cacheline adaptor.
// Optional feature macro used by this slice: CACHE_ARB_ROUND_ROBIN_EN.
package cache_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-adaptor signals around the arbiter.
// slave = arbiter view, master = environment view (caches plus adaptor).
interface cache_mem_arbiter_if;
  import cache_arb_pkg::*;

  // Handshake: a cache holds its read/write request level until its 1-cycle resp;
  // the arbiter holds mem_read/mem_write and the latched command until the 1-cycle mem_resp.
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/cache_arb_pick.sv
// Combinational winner select between I-cache and D-cache requests.
// CACHE_ARB_ROUND_ROBIN_EN: ties alternate via last_grant; otherwise D-cache wins ties.
module cache_arb_pick
  import cache_arb_pkg::*;
(
  input  logic     i_req,
  input  logic     d_req,
  input  arb_src_t last_grant,
  output logic     grant_valid,
  output arb_src_t grant_src
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_src   = SRC_I;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) begin
      grant_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
    end else if (d_req) begin
      grant_src = SRC_D;
    end
`else
    if (d_req) begin
      grant_src = SRC_D;
    end
`endif
  end

`ifndef CACHE_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the cacheline memory port between I-cache and D-cache miss engines.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin ties (default: D-cache priority).
module cache_mem_arbiter
  import cache_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  cache_mem_arbiter_if.slave bus,
  output arb_state_t         dbg_state_o
);

  arb_state_t        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic     i_req, d_req, grant_valid, grant_take;
  arb_src_t grant_src, last_grant;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  cache_arb_pick u_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  assign grant_take = (state_q == S_IDLE) && grant_valid;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  arb_src_t last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_take) last_grant_d = grant_src;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= SRC_I;
    else      last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = SRC_I;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) state_d = (grant_src == SRC_D) ? S_GRANT_D : S_GRANT_I;
      end
      S_GRANT_I, S_GRANT_D: begin
        if (bus.mem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch: loaded only on grant, so requester changes mid-grant never reach memory.
  // A simultaneous D read+write is illegal and resolves to the write-back.
  always_comb begin
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (grant_take) begin
      if (grant_src == SRC_D) begin
        mem_read_d  = bus.d_read & ~bus.d_write;
        mem_write_d = bus.d_write;
        addr_d      = bus.d_address;
        wdata_d     = bus.d_wdata;
      end else begin
        mem_read_d  = 1'b1;
        mem_write_d = 1'b0;
        addr_d      = bus.i_address;
      end
    end else if ((state_q != S_IDLE) && bus.mem_resp) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    bus.i_resp      = (state_q == S_GRANT_I) && bus.mem_resp;
    bus.d_resp      = (state_q == S_GRANT_D) && bus.mem_resp;
    bus.i_rdata     = bus.mem_rdata;
    bus.d_rdata     = bus.mem_rdata;
    bus.mem_read    = mem_read_q;
    bus.mem_write   = mem_write_q;
    bus.mem_address = addr_q;
    bus.mem_wdata   = wdata_q;
    dbg_state_o     = state_q;
  end

endmodule
